// File: rtl/dmux_pkg.sv
// Shared types and constants for the demux lane scheduler.
package dmux_pkg;

    // Scheduler FSM: waiting for a word, or holding one for its lane.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lane-selection modes as sampled from in_mode.
    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_EXPL = 1'b1;

    // Default geometry: 8 lanes, 3-bit select.
    localparam int N_OUT_DEF = 8;
    localparam int SEL_W_DEF = 3;

endpackage

// File: rtl/dmux_rr_ptr.sv
// Round-robin lane pointer: advances by one lane per enable, wrapping N_OUT-1 -> 0.
module dmux_rr_ptr
    import dmux_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [SEL_W-1:0] ptr
);

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_OUT - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    // Next pointer: step on advance, explicit wrap at the last lane.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dmux_lane_scheduler.sv
// Demux lane scheduler: takes one word at a time from a single producer, chooses
// a destination lane (round-robin or explicit), drives the demux select and holds
// the word until that lane accepts it.
// Optional feature macro DMUX_TIMEOUT_EN: when defined, a held word that its lane
// does not accept within TMO_CYC cycles is discarded with a one-cycle drop pulse.
// When undefined, drop is tied low and a held word waits indefinitely.
module dmux_lane_scheduler
    import dmux_pkg::*;
#(
    parameter int N_OUT   = N_OUT_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DATA_W  = 1,
    parameter int TMO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    input  logic [SEL_W-1:0]  in_dest,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic              drop
);

    // One-hot decode of a lane number.
    function automatic logic [N_OUT-1:0] lane_onehot(input logic [SEL_W-1:0] lane);
        logic [N_OUT-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

    state_t            state_q,    state_d;
    logic [SEL_W-1:0]  sel_q,      sel_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              mode_q,     mode_d;
    logic [N_OUT-1:0]  valid_q,    valid_d;
    logic              in_ready_q, in_ready_d;

    logic [SEL_W-1:0]  rr_ptr;
    logic              rr_adv;
    logic              accept;
    logic [SEL_W-1:0]  lane;

`ifdef DMUX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              drop_q,    drop_d;
`else
    logic              unused_tmo;
    assign unused_tmo = ^TMO_CYC;
`endif

    // Only the selected lane's ready matters; the rest are ignored.
    assign accept = out_ready[sel_q];
    assign lane   = (in_mode == MODE_EXPL) ? in_dest : rr_ptr;

    // Next-state logic: accept in IDLE, complete (or time out) in HOLD.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        data_d     = data_q;
        mode_d     = mode_q;
        valid_d    = valid_q;
        in_ready_d = in_ready_q;
        rr_adv     = 1'b0;
`ifdef DMUX_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        drop_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    mode_d     = in_mode;
                    sel_d      = lane;
                    valid_d    = lane_onehot(lane);
                    in_ready_d = 1'b0;
                    state_d    = HOLD;
`ifdef DMUX_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d    = '0;
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                    rr_adv     = (mode_q == MODE_RR);
`ifdef DMUX_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Discarded words still consume their round-robin slot.
                    valid_d    = '0;
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                    drop_d     = 1'b1;
                    rr_adv     = (mode_q == MODE_RR);
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d    = IDLE;
                valid_d    = '0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State, payload and registered outputs; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            data_q     <= '0;
            mode_q     <= MODE_RR;
            valid_q    <= '0;
            in_ready_q <= 1'b1;
`ifdef DMUX_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            drop_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            mode_q     <= mode_d;
            valid_q    <= valid_d;
            in_ready_q <= in_ready_d;
`ifdef DMUX_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            drop_q     <= drop_d;
`endif
        end
    end

    dmux_rr_ptr #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_rr_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (rr_adv),
        .ptr     (rr_ptr)
    );

    assign in_ready  = in_ready_q;
    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
`ifdef DMUX_TIMEOUT_EN
    assign drop      = drop_q;
`else
    assign drop      = 1'b0;
`endif

endmodule
